// File: rtl/pwm_duty_capture_if.sv
// pwm_duty_capture_if
//   Groups the PWM capture data path into one bundle so the capture block and
//   whatever drives/observes it share a single typed connection.
//   Signals:
//     pwm_in     [CHANNELS]          asynchronous PWM lines, bit i = channel i
//     duty       [CHANNELS*WIN_LEN]  duty word per channel, channel i at [i*WIN_LEN +: WIN_LEN]
//     duty_valid                     one-cycle strobe when duty/idle were just updated
//     idle       [CHANNELS]          bit i high = channel i had no edge in the last window
//   Modports:
//     master  drives pwm_in, observes the results (source / checker side)
//     slave   the capture block itself
interface pwm_duty_capture_if #(
  parameter int CHANNELS = 8,
  parameter int WIN_LEN  = 8
);
  logic [CHANNELS-1:0]         pwm_in;
  logic [CHANNELS*WIN_LEN-1:0] duty;
  logic                        duty_valid;
  logic [CHANNELS-1:0]         idle;

  modport master (
    output pwm_in,
    input  duty,
    input  duty_valid,
    input  idle
  );

  modport slave (
    input  pwm_in,
    output duty,
    output duty_valid,
    output idle
  );
endinterface

// File: rtl/pwm_duty_capture.sv
// pwm_duty_capture
//   Measures the duty cycle of CHANNELS asynchronous PWM lines by counting high
//   samples over a free-running window of 2^WIN_LEN clock cycles. At the end of
//   every window it publishes a saturated WIN_LEN-bit duty word per channel, a
//   per-channel idle flag (set when the line did not toggle during that window)
//   and a one-cycle duty_valid strobe.
//   Ports:
//     clk  system clock, rising edge
//     rst  synchronous active-high reset
//     bus  pwm_duty_capture_if.slave (pwm_in in; duty, duty_valid, idle out)
module pwm_duty_capture #(
  parameter int CHANNELS = 8,
  parameter int WIN_LEN  = 8
) (
  input  logic               clk,
  input  logic               rst,
  pwm_duty_capture_if.slave  bus
);

  // s1/s2 form the synchronizer, s3 is the previous s2 for edge detection
  logic [CHANNELS-1:0]               s1_q, s1_d;
  logic [CHANNELS-1:0]               s2_q, s2_d;
  logic [CHANNELS-1:0]               s3_q, s3_d;
  logic [WIN_LEN-1:0]                win_q, win_d;
  // One extra bit so a line that is high for the full window can reach 2^WIN_LEN
  logic [CHANNELS-1:0][WIN_LEN:0]    acc_q, acc_d;
  logic [CHANNELS-1:0]               edge_seen_q, edge_seen_d;
  logic [CHANNELS*WIN_LEN-1:0]       duty_q, duty_d;
  logic [CHANNELS-1:0]               idle_q, idle_d;
  logic                              valid_q, valid_d;
  logic                              boundary;

  assign boundary       = &win_q;
  assign bus.duty       = duty_q;
  assign bus.idle       = idle_q;
  assign bus.duty_valid = valid_q;

  // Next-state for the whole capture path. The boundary slot still takes its
  // own sample and edge into the closing window before the accumulators clear.
  always_comb begin
    logic [WIN_LEN:0] total;
    logic             changed;
    total       = '0;
    changed     = 1'b0;
    s1_d        = bus.pwm_in;
    s2_d        = s1_q;
    s3_d        = s2_q;
    win_d       = win_q + WIN_LEN'(1);
    acc_d       = acc_q;
    edge_seen_d = edge_seen_q;
    duty_d      = duty_q;
    idle_d      = idle_q;
    valid_d     = boundary;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      total   = acc_q[ch] + (WIN_LEN+1)'(s2_q[ch]);
      changed = s2_q[ch] ^ s3_q[ch];
      if (boundary) begin
        acc_d[ch]                     = '0;
        edge_seen_d[ch]               = 1'b0;
        // Only a line high in every slot overflows WIN_LEN bits; clamp it to all-ones
        duty_d[ch*WIN_LEN +: WIN_LEN] = total[WIN_LEN] ? {WIN_LEN{1'b1}} : total[WIN_LEN-1:0];
        idle_d[ch]                    = ~(edge_seen_q[ch] | changed);
      end else begin
        acc_d[ch]       = total;
        edge_seen_d[ch] = edge_seen_q[ch] | changed;
      end
    end
  end

  // State register; reset discards any partial window and clears the outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q        <= '0;
      s2_q        <= '0;
      s3_q        <= '0;
      win_q       <= '0;
      acc_q       <= '0;
      edge_seen_q <= '0;
      duty_q      <= '0;
      idle_q      <= '0;
      valid_q     <= 1'b0;
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      s3_q        <= s3_d;
      win_q       <= win_d;
      acc_q       <= acc_d;
      edge_seen_q <= edge_seen_d;
      duty_q      <= duty_d;
      idle_q      <= idle_d;
      valid_q     <= valid_d;
    end
  end

endmodule
